// File: rtl/arb_req_pkg.sv
// Shared types and default sizing for the arbitration requester agent.
package arb_req_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_e;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned LEN_W_DEF    = 4;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned MAX_WAIT_DEF = 32;

endpackage

// File: rtl/arb_requester_agent_watchdog.sv
// Starvation watchdog: counts consecutive request-without-grant cycles and
// raises a sticky flag when the limit is reached.
module arb_wait_watchdog
  import arb_req_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic i_clr,
  input  logic i_active,
  output logic o_starve_err
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_starve_err;
  logic              w_waiting;
  logic              w_hit;

  assign w_waiting    = i_req & ~i_gnt;
  assign w_hit        = w_waiting & (r_wait_cnt == WAIT_LAST);
  assign o_starve_err = r_starve_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt   <= '0;
      r_starve_err <= 1'b0;
    end else begin
      // Counter parks at the limit so a long stall keeps re-asserting the flag.
      if (!i_active || i_gnt) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && (r_wait_cnt != WAIT_LAST)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_hit) begin
        r_starve_err <= 1'b1;
      end else if (i_clr) begin
        r_starve_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arb_requester_agent.sv
// Client end of a REQ/GNT round-robin arbiter: moves a burst of write beats
// onto the shared bus only in granted cycles, with error and beat reporting.
module arb_requester_agent
  import arb_req_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_req,
  input  logic              i_gnt,
  output logic              o_bus_valid,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_bus_last,
  output logic              o_done,
  output logic              o_starve_err,
  output logic              o_proto_err,
  input  logic              i_err_clr,
  output logic [CNT_W-1:0]  o_beat_total
);

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_idx;
  logic [CNT_W-1:0]   r_beat_total;
  logic               r_proto_err;
  logic               w_active;
  logic               w_fire;
  logic               w_last;

  assign w_active = (r_state == StActive);
  assign w_fire   = w_active & i_gnt & i_wr_valid;
  assign w_last   = w_fire & (r_beat_idx == r_len);

  // gnt is a register output in the arbiter, so req may depend on it.
  assign o_req        = w_active & ~w_last;
  assign o_bus_valid  = w_fire;
  assign o_wr_ready   = w_fire;
  assign o_bus_data   = w_fire ? i_wr_data : '0;
  assign o_bus_last   = w_last;
  assign o_cmd_ready  = (r_state == StIdle);
  assign o_done       = (r_state == StDone);
  assign o_proto_err  = r_proto_err;
  assign o_beat_total = r_beat_total;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_beat_idx <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_len      <= i_cmd_len;
            r_beat_idx <= '0;
            r_state    <= StActive;
          end
        end
        StActive: begin
          if (w_fire) r_beat_idx <= r_beat_idx + 1'b1;
          if (w_last) r_state <= StDone;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // A grant in the DONE cycle is arbiter lag, so only IDLE grants are errors.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_proto_err  <= 1'b0;
      r_beat_total <= '0;
    end else begin
      if ((r_state == StIdle) && i_gnt) begin
        r_proto_err <= 1'b1;
      end else if (i_err_clr) begin
        r_proto_err <= 1'b0;
      end
      if (w_fire && (r_beat_total != '1)) begin
        r_beat_total <= r_beat_total + 1'b1;
      end
    end
  end

  arb_wait_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (o_req),
    .i_gnt        (i_gnt),
    .i_clr        (i_err_clr),
    .i_active     (w_active),
    .o_starve_err (o_starve_err)
  );

endmodule

// File: tb/tb_arb_requester_agent.sv
// Directed bench for arb_requester_agent with a beat scoreboard; a second
// instance with a 2-bit beat counter checks saturation on the same stimulus.
module tb_arb_requester_agent;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        gnt = 1'b0;
  logic        err_clr = 1'b0;

  logic        cmd_ready, wr_ready, req, bus_valid, bus_last, done, starve_err, proto_err;
  logic [7:0]  bus_data;
  logic [15:0] beat_total;

  logic        s_cmd_ready, s_wr_ready, s_req, s_bus_valid, s_bus_last, s_done;
  logic        s_starve_err, s_proto_err;
  logic [7:0]  s_bus_data;
  logic [1:0]  s_beat_total;

  int          checks = 0;
  int          errors = 0;
  beat_t       sb_q[$];
  logic        gnt_follow = 1'b0;
  logic        last_req = 1'b0;

  always #5 clk = ~clk;

  arb_requester_agent #(
    .DATA_W   (8),
    .LEN_W    (4),
    .MAX_WAIT (4),
    .CNT_W    (16)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_len    (cmd_len),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_data    (wr_data),
    .o_req        (req),
    .i_gnt        (gnt),
    .o_bus_valid  (bus_valid),
    .o_bus_data   (bus_data),
    .o_bus_last   (bus_last),
    .o_done       (done),
    .o_starve_err (starve_err),
    .o_proto_err  (proto_err),
    .i_err_clr    (err_clr),
    .o_beat_total (beat_total)
  );

  arb_requester_agent #(
    .DATA_W   (8),
    .LEN_W    (4),
    .MAX_WAIT (32),
    .CNT_W    (2)
  ) u_sat (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (s_cmd_ready),
    .i_cmd_len    (cmd_len),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (s_wr_ready),
    .i_wr_data    (wr_data),
    .o_req        (s_req),
    .i_gnt        (gnt),
    .o_bus_valid  (s_bus_valid),
    .o_bus_data   (s_bus_data),
    .o_bus_last   (s_bus_last),
    .o_done       (s_done),
    .o_starve_err (s_starve_err),
    .o_proto_err  (s_proto_err),
    .i_err_clr    (err_clr),
    .o_beat_total (s_beat_total)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic nxt();
    @(posedge clk);
    #1;
    if (gnt_follow) gnt = last_req;
  endtask

  // Sample at the falling edge and retire any bus beat against the scoreboard.
  task automatic smp();
    beat_t exp_b;
    @(negedge clk);
    last_req = req;
    if (bus_valid) begin
      chk("sb_underflow", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_b = sb_q.pop_front();
        chk("bus_data", 32'(bus_data), 32'(exp_b.data));
        chk("bus_last", 32'(bus_last), 32'(exp_b.last));
      end
    end else begin
      chk("bus_data_idle", 32'(bus_data), 32'd0);
      chk("bus_last_idle", 32'(bus_last), 32'd0);
    end
    chk("wr_ready_eq_valid", 32'(wr_ready), 32'(bus_valid));
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb_q.push_back(b);
  endtask

  initial begin
    logic [6:0] pat;
    int         idx;

    // Reset state
    rst = 1'b1;
    nxt();
    nxt();
    smp();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errs", 32'({starve_err, proto_err}), 32'd0);
    chk("rst_total", 32'(beat_total), 32'd0);

    // 1: single beat, gnt follows req by one cycle
    nxt();
    rst = 1'b0;
    gnt_follow = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h5A;
    push(8'h5A, 1'b1);
    cmd_valid = 1'b1;
    cmd_len = 4'd0;
    smp();
    chk("t1_accept_ready", 32'(cmd_ready), 32'd1);
    chk("t1_req_t0", 32'(req), 32'd0);
    nxt();
    cmd_valid = 1'b0;
    smp();
    chk("t1_req_t1", 32'(req), 32'd1);
    chk("t1_valid_t1", 32'(bus_valid), 32'd0);
    nxt();
    smp();
    chk("t1_valid_t2", 32'(bus_valid), 32'd1);
    chk("t1_req_t2", 32'(req), 32'd0);
    nxt();
    smp();
    chk("t1_done_t3", 32'(done), 32'd1);
    nxt();
    smp();
    chk("t1_done_t4", 32'(done), 32'd0);
    chk("t1_total", 32'(beat_total), 32'd1);
    chk("t1_proto", 32'(proto_err), 32'd0);

    // 2: four beats under grant pattern 1,0,0,1,1,0,1
    gnt_follow = 1'b0;
    pat = 7'b1011001;
    idx = 0;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), (i == 3));
    nxt();
    gnt = 1'b0;
    cmd_valid = 1'b1;
    cmd_len = 4'd3;
    smp();
    nxt();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) nxt();
      gnt = pat[i];
      wr_data = 8'hA0 + 8'(idx);
      smp();
      chk("t2_beat_on_gnt", 32'(bus_valid), 32'(pat[i]));
      chk("t2_req", 32'(req), (i == 6) ? 32'd0 : 32'd1);
      if (bus_valid) idx++;
    end
    nxt();
    gnt = 1'b0;
    smp();
    chk("t2_done", 32'(done), 32'd1);
    nxt();
    smp();
    chk("t2_total", 32'(beat_total), 32'd5);
    chk("t2_sat_total", 32'(s_beat_total), 32'd3);
    chk("t2_errs", 32'({starve_err, proto_err}), 32'd0);

    // 3: upstream stall with continuous grant
    push(8'hB0, 1'b0);
    push(8'hB1, 1'b1);
    nxt();
    wr_valid = 1'b0;
    cmd_valid = 1'b1;
    cmd_len = 4'd1;
    smp();
    nxt();
    cmd_valid = 1'b0;
    gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt();
      smp();
      chk("t3_stall_valid", 32'(bus_valid), 32'd0);
      chk("t3_stall_ready", 32'(wr_ready), 32'd0);
      chk("t3_stall_req", 32'(req), 32'd1);
    end
    nxt();
    wr_valid = 1'b1;
    wr_data = 8'hB0;
    smp();
    chk("t3_beat0", 32'(bus_valid), 32'd1);
    nxt();
    wr_data = 8'hB1;
    smp();
    chk("t3_beat1_last", 32'(bus_last), 32'd1);
    chk("t3_beat1_req", 32'(req), 32'd0);
    nxt();
    gnt = 1'b0;
    wr_valid = 1'b0;
    smp();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_errs", 32'({starve_err, proto_err}), 32'd0);
    nxt();
    smp();
    chk("t3_total", 32'(beat_total), 32'd7);

    // 4: starvation with MAX_WAIT=4
    push(8'hC0, 1'b1);
    nxt();
    wr_valid = 1'b1;
    wr_data = 8'hC0;
    cmd_valid = 1'b1;
    cmd_len = 4'd0;
    smp();
    nxt();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      smp();
      chk("t4_no_starve_yet", 32'(starve_err), 32'd0);
      chk("t4_req", 32'(req), 32'd1);
    end
    nxt();
    err_clr = 1'b1;
    smp();
    chk("t4_starve_set", 32'(starve_err), 32'd1);
    nxt();
    err_clr = 1'b0;
    smp();
    chk("t4_set_wins", 32'(starve_err), 32'd1);
    nxt();
    gnt = 1'b1;
    smp();
    chk("t4_beat_last", 32'(bus_last), 32'd1);
    nxt();
    gnt = 1'b0;
    err_clr = 1'b1;
    smp();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_still_set", 32'(starve_err), 32'd1);
    nxt();
    err_clr = 1'b0;
    smp();
    chk("t4_cleared", 32'(starve_err), 32'd0);

    // 5: spurious grant in IDLE; grant in DONE is tolerated
    nxt();
    gnt = 1'b1;
    smp();
    chk("t5_proto_pre", 32'(proto_err), 32'd0);
    nxt();
    gnt = 1'b0;
    smp();
    chk("t5_proto_set", 32'(proto_err), 32'd1);
    nxt();
    err_clr = 1'b1;
    smp();
    nxt();
    err_clr = 1'b0;
    smp();
    chk("t5_proto_clr", 32'(proto_err), 32'd0);
    push(8'hD0, 1'b1);
    nxt();
    wr_data = 8'hD0;
    cmd_valid = 1'b1;
    cmd_len = 4'd0;
    smp();
    nxt();
    cmd_valid = 1'b0;
    gnt = 1'b1;
    smp();
    chk("t5_beat_last", 32'(bus_last), 32'd1);
    nxt();
    smp();
    chk("t5_done", 32'(done), 32'd1);
    nxt();
    gnt = 1'b0;
    smp();
    chk("t5_done_gnt_ok", 32'(proto_err), 32'd0);
    chk("t5_total", 32'(beat_total), 32'd9);
    chk("t5_sat_total", 32'(s_beat_total), 32'd3);

    // 6: reset during beat 2 of an 8-beat burst
    push(8'hE0, 1'b0);
    push(8'hE1, 1'b0);
    nxt();
    cmd_valid = 1'b1;
    cmd_len = 4'd7;
    smp();
    nxt();
    cmd_valid = 1'b0;
    gnt = 1'b1;
    wr_data = 8'hE0;
    smp();
    chk("t6_beat0", 32'(bus_valid), 32'd1);
    nxt();
    wr_data = 8'hE1;
    rst = 1'b1;
    smp();
    chk("t6_beat1", 32'(bus_valid), 32'd1);
    nxt();
    rst = 1'b0;
    gnt = 1'b0;
    smp();
    chk("t6_req_cleared", 32'(req), 32'd0);
    chk("t6_total_cleared", 32'(beat_total), 32'd0);
    chk("t6_sat_cleared", 32'(s_beat_total), 32'd0);
    chk("t6_no_done", 32'(done), 32'd0);
    chk("t6_idle", 32'(cmd_ready), 32'd1);
    nxt();
    smp();
    chk("t6_no_done_late", 32'(done), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
